// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 2:1 data mux with bounded bursts.
// Drives the registered grants and sel, and registers the selected data together with a valid flag.
module mux_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req_0,
  input  logic req_1,
  input  logic din_0,
  input  logic din_1,
  output logic gnt_0,
  output logic gnt_1,
  output logic sel,
  output logic mux_out,
  output logic valid_out
);

  // state | meaning
  // IDLE  | no grant; sel holds the last granted source
  // GNT0  | requester 0 owns the mux path
  // GNT1  | requester 1 owns the mux path
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_winner_q, last_winner_d;
  logic             sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_winner_q <= 1'b1;
      gnt_0         <= 1'b0;
      gnt_1         <= 1'b0;
      sel           <= 1'b0;
      mux_out       <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
      gnt_0         <= (state_d == GNT0);
      gnt_1         <= (state_d == GNT1);
      sel           <= sel_d;
      mux_out       <= sel ? din_1 : din_0;
      valid_out     <= gnt_0 | gnt_1;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_winner_d = last_winner_q;
    sel_d         = sel;

    case (state_q)
      IDLE: begin
        if (req_0 && req_1)
          state_d = last_winner_q ? GNT0 : GNT1;
        else if (req_0)
          state_d = GNT0;
        else if (req_1)
          state_d = GNT1;
      end
      GNT0: begin
        if (!req_0)
          state_d = req_1 ? GNT1 : IDLE;
        else if (req_1 && (cnt_q == CNT_LAST))
          state_d = GNT1;
        else if (cnt_q != CNT_LAST)
          cnt_d = cnt_q + 1'b1;
      end
      GNT1: begin
        if (!req_1)
          state_d = req_0 ? GNT0 : IDLE;
        else if (req_0 && (cnt_q == CNT_LAST))
          state_d = GNT0;
        else if (cnt_q != CNT_LAST)
          cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A fresh grant restarts the burst and moves sel; IDLE leaves sel alone.
    if (state_d == GNT0 && state_q != GNT0) begin
      cnt_d         = '0;
      sel_d         = 1'b0;
      last_winner_d = 1'b0;
    end else if (state_d == GNT1 && state_q != GNT1) begin
      cnt_d         = '0;
      sel_d         = 1'b1;
      last_winner_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_0, req_1, din_0, din_1;
  logic gnt_0, gnt_1, sel, mux_out, valid_out;

  logic rst_h1, req_0_h1, req_1_h1, din_0_h1, din_1_h1;
  logic gnt_0_h1, gnt_1_h1, sel_h1, mux_out_h1, valid_out_h1;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req_0(req_0), .req_1(req_1), .din_0(din_0), .din_1(din_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .sel(sel), .mux_out(mux_out), .valid_out(valid_out)
  );

  mux_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(3)) dut_h1 (
    .clk(clk), .rst(rst_h1), .req_0(req_0_h1), .req_1(req_1_h1), .din_0(din_0_h1), .din_1(din_1_h1),
    .gnt_0(gnt_0_h1), .gnt_1(gnt_1_h1), .sel(sel_h1), .mux_out(mux_out_h1), .valid_out(valid_out_h1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_0 = 1'b1; req_1 = 1'b1; din_0 = 1'b1; din_1 = 1'b1;
    tick();
    tick();
    checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL reset_gnt_0 got=%b exp=0", gnt_0); end
    checks++; if (gnt_1 !== 1'b0) begin errors++; $display("FAIL reset_gnt_1 got=%b exp=0", gnt_1); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
    checks++; if (mux_out !== 1'b0) begin errors++; $display("FAIL reset_mux_out got=%b exp=0", mux_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    // First tie after reset goes to requester 0.
    rst = 1'b0;
    tick();
    checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL reset_first_tie got=%b%b exp=10", gnt_0, gnt_1); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_0 = 1'b1; din_0 = 1'b1; din_1 = 1'b0;
    tick();
    tick();
    checks++; if (valid_out !== 1'b1 || mux_out !== 1'b1) begin errors++; $display("FAIL midburst_pre got valid=%b mux=%b exp 1 1", valid_out, mux_out); end
    rst = 1'b1;
    tick();
    checks++; if (gnt_0 !== 1'b0) begin errors++; $display("FAIL midburst_gnt_0 got=%b exp=0", gnt_0); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL midburst_sel got=%b exp=0", sel); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midburst_valid got=%b exp=0", valid_out); end
    checks++; if (mux_out !== 1'b0) begin errors++; $display("FAIL midburst_mux got=%b exp=0", mux_out); end
    rst = 1'b0;
    tick();
    checks++; if (gnt_0 !== 1'b1) begin errors++; $display("FAIL midburst_regrant got=%b exp=1", gnt_0); end
  endtask

  task automatic test_single_req1();
    do_reset();
    din_0 = 1'b0; din_1 = 1'b1; req_1 = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL single_c1 got gnt_1=%b sel=%b exp 1 1", gnt_1, sel); end
    checks++; if (valid_out !== 1'b0 || mux_out !== 1'b0) begin errors++; $display("FAIL single_c1_data got valid=%b mux=%b exp 0 0", valid_out, mux_out); end
    tick();
    checks++; if (valid_out !== 1'b1 || mux_out !== 1'b1) begin errors++; $display("FAIL single_c2_data got valid=%b mux=%b exp 1 1", valid_out, mux_out); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0 || mux_out !== 1'b1) begin
        errors++; $display("FAIL single_hold[%0d] got gnt=%b%b mux=%b exp 01 1", i, gnt_0, gnt_1, mux_out);
      end
    end
  endtask

  // Continues from an active GNT1 with req_0 low.
  task automatic test_release_idle();
    req_1 = 1'b0;
    tick();
    checks++; if (gnt_0 !== 1'b0 || gnt_1 !== 1'b0) begin errors++; $display("FAIL idle_gnt got=%b%b exp=00", gnt_0, gnt_1); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL idle_sel got=%b exp=1", sel); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL idle_valid_lag got=%b exp=1", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_valid_fall got=%b exp=0", valid_out); end
    checks++; if (sel !== 1'b1 || mux_out !== 1'b1) begin errors++; $display("FAIL idle_sel_hold got sel=%b mux=%b exp 1 1", sel, mux_out); end
  endtask

  task automatic test_tie_break();
    logic exp0;
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp0 = (((i - 1) / 4) % 2) == 0;
      checks++; if (gnt_0 !== exp0 || gnt_1 !== !exp0 || sel !== !exp0) begin
        errors++; $display("FAIL tie_cycle[%0d] got gnt=%b%b sel=%b exp gnt_0=%b", i, gnt_0, gnt_1, sel, exp0);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req_0 = 1'b1;
    tick();
    req_1 = 1'b1;
    tick();
    checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL early_hold got=%b%b exp=10", gnt_0, gnt_1); end
    req_0 = 1'b0;
    tick();
    checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0 || sel !== 1'b1) begin errors++; $display("FAIL early_handoff got gnt=%b%b sel=%b exp 01 1", gnt_0, gnt_1, sel); end
    // requester 1 drops while requester 0 raises: grant moves to requester 0
    req_1 = 1'b0; req_0 = 1'b1;
    tick();
    checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL drop_raise got=%b%b exp=10", gnt_0, gnt_1); end
    req_1 = 1'b1;
    tick();
    checks++; if (gnt_0 !== 1'b1 || gnt_1 !== 1'b0) begin errors++; $display("FAIL drop_raise_keep got=%b%b exp=10", gnt_0, gnt_1); end
    // Go idle with last_winner=0, then a tie goes to requester 1.
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    req_0 = 1'b1; req_1 = 1'b1;
    tick();
    checks++; if (gnt_1 !== 1'b1 || gnt_0 !== 1'b0) begin errors++; $display("FAIL idle_tie_rr got=%b%b exp=01", gnt_0, gnt_1); end
  endtask

  task automatic test_hold1_alternation();
    logic exp0;
    rst_h1 = 1'b1;
    tick();
    rst_h1 = 1'b0; din_0_h1 = 1'b0; din_1_h1 = 1'b1; req_0_h1 = 1'b1; req_1_h1 = 1'b1;
    tick();
    checks++; if (gnt_0_h1 !== 1'b1 || gnt_1_h1 !== 1'b0) begin errors++; $display("FAIL h1_first got=%b%b exp=10", gnt_0_h1, gnt_1_h1); end
    for (int i = 2; i <= 9; i++) begin
      tick();
      exp0 = (i % 2) == 1;
      checks++; if (gnt_0_h1 !== exp0 || gnt_1_h1 !== !exp0) begin
        errors++; $display("FAIL h1_gnt[%0d] got=%b%b exp gnt_0=%b", i, gnt_0_h1, gnt_1_h1, exp0);
      end
      checks++; if (mux_out_h1 !== exp0 || valid_out_h1 !== 1'b1) begin
        errors++; $display("FAIL h1_mux[%0d] got mux=%b valid=%b exp mux=%b valid=1", i, mux_out_h1, valid_out_h1, exp0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && gnt_0 === 1'b1 && gnt_1 === 1'b1) begin
      errors++;
      $display("FAIL mutex got gnt=11 exp at most one");
    end
  end

  initial begin
    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; din_0 = 1'b0; din_1 = 1'b0;
    rst_h1 = 1'b1; req_0_h1 = 1'b0; req_1_h1 = 1'b0; din_0_h1 = 1'b0; din_1_h1 = 1'b0;
    test_reset();
    test_reset_mid_burst();
    test_single_req1();
    test_release_idle();
    test_tie_break();
    test_early_release();
    test_hold1_alternation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
